// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / divide unit with HI/LO registers.
// One radix-2 step per cycle: 32 CALC cycles, then one FIX cycle for signs.
module mul_div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t      state, state_next;
   logic [5:0]  cnt;
   logic [63:0] p;          // mult: {partial, multiplier}; div: {remainder, quotient}
   logic [31:0] mag_b_q;
   logic [31:0] a_q;
   logic        is_div, neg_q, neg_r, div_zero;
   logic        done_q;

   logic        accept, mt_write;
   logic        signed_op, sa, sb;
   logic [31:0] mag_a, mag_b;
   logic [32:0] mul_sum;
   logic [63:0] mul_step, div_step;
   logic [32:0] trial;
   logic [33:0] diff;
   logic [63:0] prod;
   logic [31:0] quot, rem;

   assign accept   = (state == IDLE) && start && !flush && (op[2] == 1'b0);
   assign mt_write = (state == IDLE) && start && !flush && (op[2:1] == 2'b10);

   always_comb begin
      state_next = state;
      busy       = (state != IDLE);
      case (state)
         IDLE:    if (accept) state_next = CALC;
         CALC:    if (cnt == 6'd31) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush) state_next = IDLE;
   end

   assign done = done_q;

   // Operand magnitudes; unsigned ops never see a sign.
   assign signed_op = ~op[0];
   assign sa        = signed_op & a[31];
   assign sb        = signed_op & b[31];
   assign mag_a     = sa ? (~a + 32'd1) : a;
   assign mag_b     = sb ? (~b + 32'd1) : b;

   assign mul_sum  = {1'b0, p[63:32]} + (p[0] ? {1'b0, mag_b_q} : 33'd0);
   assign mul_step = {mul_sum, p[31:1]};

   // Restoring step: a borrow means keep the shifted remainder.
   assign trial    = {p[63:32], p[31]};
   assign diff     = {1'b0, trial} - {2'b00, mag_b_q};
   assign div_step = diff[33] ? {trial[31:0], p[30:0], 1'b0}
                              : {diff[31:0],  p[30:0], 1'b1};

   assign prod = neg_q ? (~p + 64'd1) : p;
   assign quot = neg_q ? (~p[31:0] + 32'd1) : p[31:0];
   assign rem  = neg_r ? (~p[63:32] + 32'd1) : p[63:32];

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 6'd0;
         p        <= 64'd0;
         mag_b_q  <= 32'd0;
         a_q      <= 32'd0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         done_q   <= 1'b0;
         hi       <= 32'd0;
         lo       <= 32'd0;
      end else begin
         state  <= state_next;
         done_q <= (state == FIX) && !flush;
         if (accept) begin
            p        <= {32'd0, mag_a};
            mag_b_q  <= mag_b;
            a_q      <= a;
            is_div   <= op[1];
            neg_q    <= sa ^ sb;
            neg_r    <= sa;
            div_zero <= (b == 32'd0);
            cnt      <= 6'd0;
         end else if (state == CALC) begin
            p   <= is_div ? div_step : mul_step;
            cnt <= cnt + 6'd1;
         end
         if (state == FIX && !flush) begin
            if (!is_div) begin
               hi <= prod[63:32];
               lo <= prod[31:0];
            end else if (div_zero) begin
               hi <= a_q;
               lo <= 32'hFFFF_FFFF;
            end else begin
               hi <= rem;
               lo <= quot;
            end
         end
         if (mt_write) begin
            if (op[0]) lo <= a;
            else       hi <= a;
         end
      end
   end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have ports: clk input 1 (rising-edge clock); reset input 1 (synchronous, active-high); start input 1 (operation request, EX stage); op input 3 (000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 11x no-op); a input 32 (srcA, same operand as ALU a); b input 32 (srcB, same operand as ALU b); flush input 1 (cancel in-flight operation); busy output 1 (unit occupied, drives hazard stall); done output 1 (one-cycle completion pulse); hi output 32 (HI register); lo output 32 (LO register).
REQ-002 The block SHALL use one clock, clk, with reset synchronous and active-high; it SHALL NOT use any asynchronous reset or second clock.

Function
REQ-003 States SHALL be IDLE, CALC and FIX; the machine SHALL be in IDLE out of reset.
REQ-004 In IDLE, start=1 with op in {000..011} and flush=0 SHALL, at edge E0: latch operand magnitudes and signs, clear the 6-bit iteration counter, and enter CALC.
REQ-005 CALC SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring subtract for divide, on 32-bit unsigned magnitudes, for exactly 32 cycles (E1..E32), then enter FIX.
REQ-006 FIX SHALL apply sign correction at E33, write hi and lo, and return to IDLE. done SHALL be 1 for exactly the cycle after E33.
REQ-007 busy SHALL be 1 from after E0 through E33 inclusive (33 cycles) and 0 otherwise; busy SHALL be 0 in the cycle done is 1.
REQ-008 mult/multu SHALL produce the 64-bit product {hi,lo}. For mult, the 64-bit magnitude product SHALL be negated when sign(a) XOR sign(b).
REQ-009 div/divu SHALL produce lo = quotient and hi = remainder. For div, the quotient SHALL be negative iff sign(a) XOR sign(b); the remainder sign SHALL follow a (truncating division).
REQ-010 Divide by zero (b=0, div or divu) SHALL give lo=32'hFFFFFFFF and hi=a, with the same 33-cycle latency.
REQ-011 div with a=32'h80000000 and b=32'hFFFFFFFF SHALL give lo=32'h80000000 and hi=0.
REQ-012 mthi/mtlo with start=1 in IDLE SHALL write a to hi or lo at that edge, with no busy and no done; the other register SHALL be unchanged.
REQ-013 start while busy=1 SHALL be ignored, including mthi/mtlo. Hazard logic holds the instruction using busy.
REQ-014 start with op=11x SHALL have no effect.
REQ-015 flush=1 SHALL return the machine to IDLE at the next edge from any state, leaving hi/lo unchanged and done=0. flush together with start SHALL discard the start.
REQ-016 hi/lo SHALL change only per REQ-006, REQ-012 or reset; intermediate partial results SHALL stay internal.
REQ-017 A new start SHALL be accepted in the cycle done=1, because the machine is in IDLE then.

Reset
REQ-018 reset=1 at an edge SHALL force IDLE, busy=0, done=0, hi=0, lo=0 and counter=0, overriding start and flush, including mid-CALC or FIX.
REQ-019 After reset deasserts, the first start SHALL be accepted at the first edge with reset=0.

Verification
REQ-020 mult with a=32'hFFFFFFFE (-2) and b=3 -> busy for 33 cycles, then hi=32'hFFFFFFFF and lo=32'hFFFFFFFA, with a single done pulse.
REQ-021 multu with a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE and lo=32'h00000001 after E33.
REQ-022 div with a=-7 and b=2 -> lo=32'hFFFFFFFD (-3) and hi=32'hFFFFFFFF (-1). divu with a=7 and b=0 -> lo=32'hFFFFFFFF and hi=7.
REQ-023 Start mult, then assert flush at cycle 10 -> busy=0 next cycle, done never pulses, and hi/lo keep their prior values. Start mtlo with a=32'h12345678 while busy -> lo unchanged.
REQ-024 Assert reset at cycle 20 of a divu -> next cycle busy=0, done=0 and hi=lo=0. Then mthi with a=32'hA5A5A5A5 -> hi=32'hA5A5A5A5 at the following edge.
REQ-025 Issue back-to-back mult ops with the second start in the done cycle -> the second result appears exactly 34 cycles after the first result.
